// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the EX/MEM register record for the MIPS pipeline.
package mips_pkg;
    localparam logic [3:0] SZ_BYTE  = 4'b1000;
    localparam logic [3:0] SZ_BYTEU = 4'b0100;
    localparam logic [3:0] SZ_HALF  = 4'b0010;
    localparam logic [3:0] SZ_WORD  = 4'b0001;

    localparam logic [3:0] BYTEEN_NONE  = 4'b0000;
    localparam logic [3:0] BYTEEN_BYTE0 = 4'b0001;
    localparam logic [3:0] BYTEEN_LO    = 4'b0011;
    localparam logic [3:0] BYTEEN_HI    = 4'b1100;
    localparam logic [3:0] BYTEEN_ALL   = 4'b1111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        misalign;
        logic [4:0]  waddr;
        logic [3:0]  size;
        logic [3:0]  byte_en;
        logic [31:0] store;
        logic [31:0] alu;
    } exmem_t;
endpackage

// File: rtl/store_align.sv
// store_align: lane-replicates store data, builds byte enables and flags misaligned accesses.
// Misalignment is only detected when EXMEM_MISALIGN_TRAP_EN is defined.
module store_align
    import mips_pkg::*;
(
    input  logic [3:0]  size,
    input  logic [1:0]  lane,
    input  logic        we,
    input  logic [31:0] data,
    output logic [31:0] data_o,
    output logic [3:0]  byte_en,
    output logic        misalign
);
    logic is_byte, is_half;

    // Anything that is not a clean single byte/half one-hot decodes as a word.
    always_comb begin
        is_byte = (size == SZ_BYTE) || (size == SZ_BYTEU);
        is_half = size == SZ_HALF;
        data_o  = is_byte ? {4{data[7:0]}} : (is_half ? {2{data[15:0]}} : data);
        byte_en = !we ? BYTEEN_NONE :
                  is_byte ? (BYTEEN_BYTE0 << lane) :
                  is_half ? (lane[1] ? BYTEEN_HI : BYTEEN_LO) : BYTEEN_ALL;
`ifdef EXMEM_MISALIGN_TRAP_EN
        misalign = is_half ? lane[0] : (!is_byte && lane != 2'd0);
`else
        misalign = 1'b0;
`endif
    end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with store alignment, misalign trap and MEM hazard outputs.
// Define EXMEM_MISALIGN_TRAP_EN to enable misaligned-access detection and counting.
module ex_mem_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [31:0]       ALU_Result_EX,
    input  logic [31:0]       StoreData_EX,
    input  logic [4:0]        WriteAddr_EX,
    input  logic              RegWrite_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              MemtoReg_EX,
    input  logic              Byte_EX,
    input  logic              ByteU_EX,
    input  logic              HalfWord_EX,
    input  logic              Word_EX,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    output logic [31:0]       ALU_Result_MEM,
    output logic [ADDR_W-1:0] MemAddr_MEM,
    output logic [31:0]       MemStore_MEM,
    output logic [3:0]        ByteEn_MEM,
    output logic [1:0]        Lane_MEM,
    output logic [3:0]        Size_MEM,
    output logic              RegWrite_MEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic              MemtoReg_MEM,
    output logic [4:0]        WriteAddr_MEM,
    output logic              Valid_MEM,
    output logic              Misalign_MEM,
    output logic [7:0]        MisalignCnt,
    output logic              FwdValid_MEM,
    output logic              LoadUse
);
    exmem_t stage_q, stage_d, cap;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] aligned;
    logic [3:0]  be;
    logic        mis, trap;

    store_align u_align (
        .size    ({Byte_EX, ByteU_EX, HalfWord_EX, Word_EX}),
        .lane    (ALU_Result_EX[1:0]),
        .we      (MemWrite_EX),
        .data    (StoreData_EX),
        .data_o  (aligned),
        .byte_en (be),
        .misalign(mis)
    );

    // A trapped access still occupies the stage but must not touch memory or the register file.
    always_comb begin
        trap           = mis & (MemRead_EX | MemWrite_EX);
        cap.valid      = 1'b1;
        cap.reg_write  = RegWrite_EX & ~trap;
        cap.mem_read   = MemRead_EX & ~trap;
        cap.mem_write  = MemWrite_EX & ~trap;
        cap.mem_to_reg = MemtoReg_EX;
        cap.misalign   = trap;
        cap.waddr      = WriteAddr_EX;
        cap.size       = {Byte_EX, ByteU_EX, HalfWord_EX, Word_EX};
        cap.byte_en    = trap ? BYTEEN_NONE : be;
        cap.store      = aligned;
        cap.alu        = ALU_Result_EX;
        stage_d        = Flush ? '0 : (Stall ? stage_q : cap);
        cnt_d          = (!Flush && !Stall && trap && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ALU_Result_MEM = stage_q.alu;
        MemAddr_MEM    = stage_q.alu[ADDR_W+1:2];
        MemStore_MEM   = stage_q.store;
        ByteEn_MEM     = stage_q.byte_en;
        Lane_MEM       = stage_q.alu[1:0];
        Size_MEM       = stage_q.size;
        RegWrite_MEM   = stage_q.reg_write;
        MemRead_MEM    = stage_q.mem_read;
        MemWrite_MEM   = stage_q.mem_write;
        MemtoReg_MEM   = stage_q.mem_to_reg;
        WriteAddr_MEM  = stage_q.waddr;
        Valid_MEM      = stage_q.valid;
        Misalign_MEM   = stage_q.misalign;
        MisalignCnt    = cnt_q;
        FwdValid_MEM   = stage_q.valid & stage_q.reg_write & ~stage_q.mem_to_reg & (stage_q.waddr != REG_ZERO);
        LoadUse        = stage_q.valid & stage_q.mem_read & (stage_q.waddr != REG_ZERO) &
                         ((stage_q.waddr == Rs_ID) | (stage_q.waddr == Rt_ID));
    end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed plus randomized checks of ex_mem_reg against a byte-level reference model.
module tb_ex_mem_reg;
`ifdef EXMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clock, Reset, Stall, Flush;
    logic [31:0] ALU_Result_EX, StoreData_EX;
    logic [4:0]  WriteAddr_EX, Rs_ID, Rt_ID;
    logic        RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX;
    logic        Byte_EX, ByteU_EX, HalfWord_EX, Word_EX;
    logic [31:0] ALU_Result_MEM, MemStore_MEM;
    logic [7:0]  MemAddr_MEM, MisalignCnt;
    logic [3:0]  ByteEn_MEM, Size_MEM;
    logic [1:0]  Lane_MEM;
    logic [4:0]  WriteAddr_MEM;
    logic        RegWrite_MEM, MemRead_MEM, MemWrite_MEM, MemtoReg_MEM;
    logic        Valid_MEM, Misalign_MEM, FwdValid_MEM, LoadUse;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_mis;
    logic [4:0]  m_wa;
    logic [3:0]  m_size, m_be;
    logic [31:0] m_store, m_alu;
    int          m_cnt;

    ex_mem_reg #(.ADDR_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ALU_Result_EX(ALU_Result_EX), .StoreData_EX(StoreData_EX), .WriteAddr_EX(WriteAddr_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemtoReg_EX(MemtoReg_EX), .Byte_EX(Byte_EX), .ByteU_EX(ByteU_EX),
        .HalfWord_EX(HalfWord_EX), .Word_EX(Word_EX), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .ALU_Result_MEM(ALU_Result_MEM), .MemAddr_MEM(MemAddr_MEM), .MemStore_MEM(MemStore_MEM),
        .ByteEn_MEM(ByteEn_MEM), .Lane_MEM(Lane_MEM), .Size_MEM(Size_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .MemtoReg_MEM(MemtoReg_MEM), .WriteAddr_MEM(WriteAddr_MEM), .Valid_MEM(Valid_MEM),
        .Misalign_MEM(Misalign_MEM), .MisalignCnt(MisalignCnt), .FwdValid_MEM(FwdValid_MEM),
        .LoadUse(LoadUse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_mis} = '0;
        m_wa = '0; m_size = '0; m_be = '0; m_store = '0; m_alu = '0;
    endtask

    // Next state from the rules: access width in bytes, start lane, byte-by-byte data replication.
    task automatic model_edge();
        int nb, a, start;
        logic [3:0] sz;
        if (Flush) begin
            model_clear();
            return;
        end
        if (Stall) return;
        sz = {Byte_EX, ByteU_EX, HalfWord_EX, Word_EX};
        a  = ALU_Result_EX % 4;
        nb = ($countones(sz) == 1 && (Byte_EX || ByteU_EX)) ? 1 :
             ($countones(sz) == 1 && HalfWord_EX) ? 2 : 4;
        start = (nb == 1) ? a : (nb == 2 ? (a >= 2 ? 2 : 0) : 0);
        m_mis = TRAP && (MemRead_EX || MemWrite_EX) && (a % nb != 0);
        m_valid = 1'b1;
        m_rw = RegWrite_EX && !m_mis;
        m_mr = MemRead_EX && !m_mis;
        m_mw = MemWrite_EX && !m_mis;
        m_m2r = MemtoReg_EX;
        m_wa = WriteAddr_EX;
        m_size = sz;
        m_alu = ALU_Result_EX;
        m_be = '0;
        if (m_mw) for (int i = start; i < start + nb; i++) m_be[i] = 1'b1;
        for (int i = 0; i < 4; i++) m_store[8*i +: 8] = StoreData_EX[8*(i % nb) +: 8];
        if (m_mis && m_cnt < 255) m_cnt++;
    endtask

    task automatic check_all();
        check("alu", ALU_Result_MEM, m_alu);
        check("memaddr", {24'd0, MemAddr_MEM}, (m_alu / 4) % 256);
        check("store", MemStore_MEM, m_store);
        check("byteen", {28'd0, ByteEn_MEM}, {28'd0, m_be});
        check("lane", {30'd0, Lane_MEM}, m_alu % 4);
        check("size", {28'd0, Size_MEM}, {28'd0, m_size});
        check("regwrite", {31'd0, RegWrite_MEM}, {31'd0, m_rw});
        check("memread", {31'd0, MemRead_MEM}, {31'd0, m_mr});
        check("memwrite", {31'd0, MemWrite_MEM}, {31'd0, m_mw});
        check("memtoreg", {31'd0, MemtoReg_MEM}, {31'd0, m_m2r});
        check("waddr", {27'd0, WriteAddr_MEM}, {27'd0, m_wa});
        check("valid", {31'd0, Valid_MEM}, {31'd0, m_valid});
        check("misalign", {31'd0, Misalign_MEM}, {31'd0, m_mis});
        check("cnt", {24'd0, MisalignCnt}, m_cnt);
        check("fwd", {31'd0, FwdValid_MEM}, {31'd0, m_valid && m_rw && !m_m2r && m_wa != 0});
        check("loaduse", {31'd0, LoadUse},
              {31'd0, m_valid && m_mr && m_wa != 0 && (m_wa == Rs_ID || m_wa == Rt_ID)});
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clock);
        #1;
        check_all();
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] d, input logic [4:0] wa,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic [3:0] sz);
        ALU_Result_EX = alu; StoreData_EX = d; WriteAddr_EX = wa;
        RegWrite_EX = rw; MemRead_EX = mr; MemWrite_EX = mw; MemtoReg_EX = m2r;
        {Byte_EX, ByteU_EX, HalfWord_EX, Word_EX} = sz;
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Rs_ID = '0; Rt_ID = '0;
        set_ex('0, '0, '0, 0, 0, 0, 0, 4'b0000);
        model_clear();
        m_cnt = 0;
        repeat (2) @(posedge Clock);
        #1;
        check_all();
        Reset = 1'b0;

        // SB at 0x13
        set_ex(32'h13, 32'h1234_56AB, 5'd0, 0, 0, 1, 0, 4'b1000);
        tick();
        check("sb_addr", {24'd0, MemAddr_MEM}, 32'h04);
        check("sb_data", MemStore_MEM, 32'hABAB_ABAB);
        check("sb_be", {28'd0, ByteEn_MEM}, 32'b1000);

        // SH at 0x22
        set_ex(32'h22, 32'h0000_BEEF, 5'd0, 0, 0, 1, 0, 4'b0010);
        tick();
        check("sh_data", MemStore_MEM, 32'hBEEF_BEEF);
        check("sh_be", {28'd0, ByteEn_MEM}, 32'b1100);

        // LW at 0x05, then a 3-cycle stall
        set_ex(32'h05, 32'h0, 5'd3, 1, 1, 0, 1, 4'b0001);
        tick();
        check("lw_mis", {31'd0, Misalign_MEM}, {31'd0, TRAP});
        check("lw_rd", {31'd0, MemRead_MEM}, {31'd0, !TRAP});
        check("lw_cnt", {24'd0, MisalignCnt}, TRAP ? 1 : 0);
        Stall = 1'b1;
        repeat (3) tick();
        check("stall_cnt", {24'd0, MisalignCnt}, TRAP ? 1 : 0);
        Stall = 1'b0;

        // load-use and forwarding
        set_ex(32'h40, 32'h0, 5'd7, 1, 1, 0, 1, 4'b0001);
        Rt_ID = 5'd7;
        tick();
        check("loaduse_r7", {31'd0, LoadUse}, 32'd1);
        set_ex(32'h1234, 32'h0, 5'd7, 1, 0, 0, 0, 4'b0000);
        tick();
        check("fwd_r7", {31'd0, FwdValid_MEM}, 32'd1);
        set_ex(32'h1234, 32'h0, 5'd0, 1, 0, 0, 0, 4'b0000);
        tick();
        check("fwd_r0", {31'd0, FwdValid_MEM}, 32'd0);
        set_ex(32'h80, 32'h0, 5'd0, 1, 1, 0, 1, 4'b0001);
        Rs_ID = 5'd0; Rt_ID = 5'd0;
        tick();
        check("loaduse_r0", {31'd0, LoadUse}, 32'd0);

        // Flush and Stall together
        set_ex(32'h10, 32'hFFFF_FFFF, 5'd9, 1, 0, 1, 0, 4'b0001);
        tick();
        Flush = 1'b1; Stall = 1'b1;
        tick();
        check("fs_valid", {31'd0, Valid_MEM}, 32'd0);
        check("fs_be", {28'd0, ByteEn_MEM}, 32'd0);
        Flush = 1'b0; Stall = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] sz;
            sz = ($urandom_range(0, 9) < 8) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            set_ex($urandom, $urandom, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), sz);
            Rs_ID = 5'($urandom_range(0, 7));
            Rt_ID = 5'($urandom_range(0, 7));
            Flush = ($urandom_range(0, 9) == 0);
            Stall = ($urandom_range(0, 4) == 0);
            tick();
        end
        Flush = 1'b0; Stall = 1'b0;

        // counter saturation with misaligned word loads
        set_ex(32'h07, 32'h0, 5'd4, 1, 1, 0, 1, 4'b0001);
        repeat (300) tick();
        check("cnt_sat", {24'd0, MisalignCnt}, TRAP ? 255 : 0);

        // asynchronous reset mid-stall
        set_ex(32'h100, 32'h55, 5'd5, 1, 0, 1, 0, 4'b0001);
        tick();
        Stall = 1'b1;
        tick();
        #2;
        Reset = 1'b1;
        model_clear();
        m_cnt = 0;
        #1;
        check_all();
        check("rst_valid", {31'd0, Valid_MEM}, 32'd0);
        Reset = 1'b0;
        Stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
